multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV64 core.
- Sequences instruction fetch, decode, execute, memory and writeback for each instruction.
- Drives the immediate-type select consumed by the immediate generator, plus the ALU, register-file, PC and memory strobes.
- Supports opcodes LOAD, OP-IMM, JALR, STORE and OP; any other opcode halts the core with a sticky illegal flag.

---
 rtl/riscv_ctrl_pkg.sv | 73 +++++++
 rtl/ctrl_timeout_cnt.sv | 31 +++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 control FSM: opcodes, states, classes, control codes.
// No logic of its own; the opcode decode helper is purely combinational.
// Backpressure: not applicable.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_LOAD  = 3'd0,
        CLS_OPIMM = 3'd1,
        CLS_JALR  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_OP    = 3'd4
    } class_t;

    typedef logic [1:0] imm_type_t;
    typedef logic [1:0] wb_sel_t;
    typedef logic [1:0] alu_op_t;

    localparam imm_type_t IMM_NONE = 2'b00;
    localparam imm_type_t IMM_I    = 2'b01;
    localparam imm_type_t IMM_S    = 2'b10;

    localparam wb_sel_t WB_ALU = 2'b00;
    localparam wb_sel_t WB_MEM = 2'b01;
    localparam wb_sel_t WB_PC4 = 2'b10;

    localparam alu_op_t ALU_ADD   = 2'b00;
    localparam alu_op_t ALU_RTYPE = 2'b01;
    localparam alu_op_t ALU_ITYPE = 2'b10;

    typedef struct packed {
        logic   vld;
        class_t cls;
    } dec_t;

    function automatic dec_t decode_opcode(input logic [6:0] opc);
        dec_t d;
        d.vld = 1'b1;
        d.cls = CLS_LOAD;
        case (opc)
            OPC_LOAD:  d.cls = CLS_LOAD;
            OPC_OPIMM: d.cls = CLS_OPIMM;
            OPC_JALR:  d.cls = CLS_JALR;
            OPC_STORE: d.cls = CLS_STORE;
            OPC_OP:    d.cls = CLS_OP;
            default:   d.vld = 1'b0;
        endcase
        return d;
    endfunction

    function automatic imm_type_t imm_type_of(input class_t cls);
        case (cls)
            CLS_LOAD, CLS_OPIMM, CLS_JALR: return IMM_I;
            CLS_STORE:                     return IMM_S;
            default:                       return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Wait-cycle counter for memory handshakes; tc flags MEM_TIMEOUT-1 unacknowledged cycles.
// Latency: tc is a registered compare, visible the cycle the count lands on the threshold.
// Backpressure: none; clr wins over en, and the count saturates at the threshold.
module ctrl_timeout_cnt #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 core; HALT on bad opcode or stalled memory.
// Latency: 4 cycles for OP/OPIMM/JALR/STORE, 5 for LOAD, plus one per memory wait cycle.
// Backpressure: waits in FETCH/MEM on single-cycle acks; a shared counter times out stalled requests.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_code,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_type,
    output logic        retire,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state_dbg
);

    state_t state_q, state_d;
    class_t cls_q;
    class_t cur_cls;
    dec_t   dec;
    logic   illegal_q, timeout_q;
    logic   illegal_set, timeout_set;
    logic   cnt_clr, cnt_en, cnt_tc;
    logic   unused_inst;

    assign dec         = decode_opcode(inst_code[6:0]);
    assign unused_inst = ^inst_code[31:12];

    // In DECODE the class register is still being loaded, so use the live decode.
    assign cur_cls = (state_q == ST_DECODE) ? dec.cls : cls_q;

    ctrl_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_LOAD;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE && dec.vld) begin
                cls_q <= dec.cls;
            end
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = WB_ALU;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        imm_type    = IMM_NONE;
        retire      = 1'b0;
        illegal_set = 1'b0;
        timeout_set = 1'b0;
        cnt_clr     = 1'b1;
        cnt_en      = 1'b0;

        // Outputs are forced quiet while reset is held, even though state already reads FETCH.
        if (!rst) begin
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                alu_src_imm = (cur_cls != CLS_OP);
                alu_op      = (cur_cls == CLS_OP)    ? ALU_RTYPE :
                              (cur_cls == CLS_OPIMM) ? ALU_ITYPE : ALU_ADD;
                imm_type    = imm_type_of(cur_cls);
            end

            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    cnt_clr  = imem_ack;
                    cnt_en   = !imem_ack;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (cnt_tc) begin
                        timeout_set = 1'b1;
                        state_d     = ST_HALT;
                    end
                end
                ST_DECODE: begin
                    if (dec.vld) begin
                        imm_type = imm_type_of(dec.cls);
                        state_d  = ST_EXEC;
                    end else begin
                        illegal_set = 1'b1;
                        state_d     = ST_HALT;
                    end
                end
                ST_EXEC: begin
                    state_d = (cur_cls == CLS_LOAD || cur_cls == CLS_STORE) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cur_cls == CLS_STORE);
                    cnt_clr  = dmem_ack;
                    cnt_en   = !dmem_ack;
                    if (dmem_ack) begin
                        if (cur_cls == CLS_STORE) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (cnt_tc) begin
                        timeout_set = 1'b1;
                        state_d     = ST_HALT;
                    end
                end
                ST_WB: begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    pc_src  = (cur_cls == CLS_JALR);
                    wb_sel  = (cur_cls == CLS_LOAD) ? WB_MEM :
                              (cur_cls == CLS_JALR) ? WB_PC4 : WB_ALU;
                    rf_we   = (inst_code[11:7] != 5'd0);
                    state_d = ST_FETCH;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected cycle traces are queued with
// their ack stimulus, then popped and compared one cycle at a time.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_code;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic        ir_we, pc_we, pc_src, rf_we, alu_src_imm, retire, illegal, timeout;
    logic [1:0]  wb_sel, alu_op, imm_type;
    logic [2:0]  state_dbg;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_code   (inst_code),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .imm_type    (imm_type),
        .retire      (retire),
        .illegal     (illegal),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, rf_we;
        logic [1:0] wb_sel;
        logic       alu_src_imm;
        logic [1:0] alu_op;
        logic [1:0] imm_type;
        logic       retire, illegal, timeout;
    } obs_t;

    obs_t obs;
    assign obs = {state_dbg, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, rf_we,
                  wb_sel, alu_src_imm, alu_op, imm_type, retire, illegal, timeout};

    logic [1:0] stim_q[$];
    obs_t       exp_q[$];
    obs_t       msk_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    string      cur_tag;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input obs_t e, input obs_t m);
        stim_q.push_back(s);
        exp_q.push_back(e);
        msk_q.push_back(m);
    endtask

    // Builds the full expected trace of one instruction. fw/mw = wait cycles before each ack.
    // Acks of the non-requesting kind are driven high deliberately and must be ignored.
    task automatic push_inst(input logic [31:0] ic, input int fw, input int mw);
        obs_t e, full, wbm;
        logic [1:0] imm, aop, wbs;
        logic src, mem, st, pcs, legal;
        legal = 1'b1; mem = 1'b0; st = 1'b0; pcs = 1'b0;
        imm = 2'b00; aop = 2'b00; wbs = 2'b00; src = 1'b1;
        case (ic[6:0])
            7'b0000011: begin imm = 2'b01; mem = 1'b1; wbs = 2'b01; end
            7'b0010011: begin imm = 2'b01; aop = 2'b10; end
            7'b1100111: begin imm = 2'b01; wbs = 2'b10; pcs = 1'b1; end
            7'b0100011: begin imm = 2'b10; mem = 1'b1; st = 1'b1; end
            7'b0110011: begin aop = 2'b01; src = 1'b0; end
            default:    legal = 1'b0;
        endcase
        inst_code = ic;
        full = '1;
        wbm = '1;
        wbm.alu_src_imm = 1'b0;
        wbm.alu_op = 2'b00;

        for (int i = 0; i < fw; i++) begin
            e = '0; e.st = 3'd0; e.imem_req = 1'b1;
            push(2'b01, e, full);
        end
        e = '0; e.st = 3'd0; e.imem_req = 1'b1; e.ir_we = 1'b1;
        push(2'b10, e, full);

        e = '0; e.st = 3'd1; e.imm_type = imm;
        push(2'b11, e, full);

        if (!legal) begin
            for (int i = 0; i < 3; i++) begin
                e = '0; e.st = 3'd5; e.illegal = 1'b1;
                push(2'b11, e, full);
            end
        end else begin
            e = '0; e.st = 3'd2; e.imm_type = imm; e.alu_op = aop; e.alu_src_imm = src;
            push(2'b11, e, full);
            if (mem) begin
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.st = 3'd3; e.dmem_req = 1'b1; e.dmem_we = st;
                    e.imm_type = imm; e.alu_op = aop; e.alu_src_imm = src;
                    if (i == mw && st) begin
                        e.pc_we = 1'b1; e.retire = 1'b1;
                    end
                    push((i == mw) ? 2'b01 : 2'b10, e, full);
                end
            end
            if (!st) begin
                e = '0; e.st = 3'd4; e.pc_we = 1'b1; e.retire = 1'b1; e.pc_src = pcs;
                e.wb_sel = wbs; e.rf_we = (ic[11:7] != 5'd0); e.imm_type = imm;
                push(2'b11, e, wbm);
            end
        end
    endtask

    task automatic push_timeout();
        obs_t e, full;
        full = '1;
        for (int i = 0; i < 16; i++) begin
            e = '0; e.st = 3'd0; e.imem_req = 1'b1;
            push(2'b01, e, full);
        end
        for (int i = 0; i < 4; i++) begin
            e = '0; e.st = 3'd5; e.timeout = 1'b1;
            push(2'b11, e, full);
        end
    endtask

    // Entered and left at posedge+1; n < 0 drains the whole queue.
    task automatic run_q(input int n);
        logic [1:0] s;
        obs_t e, m;
        int cyc = 0;
        while (stim_q.size() > 0 && (n < 0 || cyc < n)) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            imem_ack = s[1];
            dmem_ack = s[0];
            @(negedge clk);
            chk($sformatf("%s.c%0d", cur_tag, cyc), 32'(obs & m), 32'(e & m));
            @(posedge clk);
            #1;
            cyc++;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #2;
        chk({tag, ".outs"}, 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        inst_code = 32'h0;
        #3;
        chk("reset.outs", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cur_tag = "addi";   push_inst(32'h00A00093, 0, 0);  run_q(-1);
        cur_tag = "load";   push_inst(32'h0000B103, 0, 3);  run_q(-1);
        cur_tag = "store";  push_inst(32'h0020B023, 0, 0);  run_q(-1);
        cur_tag = "jalr";   push_inst(32'h00008067, 0, 0);  run_q(-1);
        cur_tag = "op";     push_inst(32'h002081B3, 2, 0);  run_q(-1);
        cur_tag = "thresh"; push_inst(32'h00A00093, 15, 0); run_q(-1);
        cur_tag = "stwait"; push_inst(32'h0020B023, 1, 2);  run_q(-1);
        cur_tag = "illeg";  push_inst(32'h0000007F, 0, 0);  run_q(-1);
        do_reset("illeg_rst");

        cur_tag = "tmo";    push_timeout();                 run_q(-1);
        do_reset("tmo_rst");

        // Async reset in the middle of a data request must drop dmem_req immediately.
        cur_tag = "rstmem"; push_inst(32'h0000B103, 0, 6);  run_q(5);
        stim_q.delete();
        exp_q.delete();
        msk_q.delete();
        #1;
        chk("rstmem.req_before", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmem.req_after", 32'(dmem_req), 32'd0);
        chk("rstmem.state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cur_tag = "recover"; push_inst(32'h002081B3, 0, 0); run_q(-1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
